// File: rtl/inst_fetch_queue.sv
// Fetch front-end: owns the PC, issues in-order fetch requests and buffers responses in a DEPTH-entry FIFO for decode.
// Head is combinational (0-cycle read); issue is credit-limited so a push never meets a full FIFO; JumpFlag redirects and flushes.
module inst_fetch_queue #(
    parameter int                 ADDR_W   = 64,
    parameter int                 INST_W   = 32,
    parameter int                 DEPTH    = 4,
    parameter logic [ADDR_W-1:0]  RESET_PC = ADDR_W'(64'h8000_0000),
    parameter int                 PC_STEP  = 4
) (
    input  logic                         Clk,
    input  logic                         Rst,
    input  logic                         JumpFlag,
    input  logic [ADDR_W-1:0]            JumpAddr,
    output logic                         FetchReqValid,
    output logic [ADDR_W-1:0]            FetchReqAddr,
    input  logic                         FetchReqReady,
    input  logic                         FetchRspValid,
    input  logic [INST_W-1:0]            FetchRspInst,
    output logic                         InstValid,
    output logic [INST_W-1:0]            InstOut,
    output logic [ADDR_W-1:0]            InstAddrOut,
    input  logic                         InstReady,
    output logic [$clog2(DEPTH+1)-1:0]   Count
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int OW = $clog2(2 * DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam int SW = OW + 1;

    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] rsp_pc;
    logic [OW-1:0]     outstanding;
    logic [OW-1:0]     drop_cnt;
    logic [CW-1:0]     count;
    logic [PW-1:0]     head;
    logic [PW-1:0]     tail;

    logic [INST_W-1:0] inst_mem [DEPTH];
    logic [ADDR_W-1:0] addr_mem [DEPTH];

    logic [SW-1:0]     credit_used;
    logic              req_fire;
    logic              push;
    logic              pop;
    logic [OW-1:0]     out_after_rsp;

    // Live responses still owed plus entries held: must stay below DEPTH to issue.
    assign credit_used   = SW'(count) + SW'(outstanding) - SW'(drop_cnt);
    assign FetchReqValid = !Rst && !JumpFlag && (credit_used < SW'(DEPTH));
    assign FetchReqAddr  = pc;
    assign req_fire      = FetchReqValid && FetchReqReady;

    assign push          = FetchRspValid && (drop_cnt == '0) && !JumpFlag;
    assign pop           = InstValid && InstReady && !JumpFlag;
    assign out_after_rsp = outstanding - OW'(FetchRspValid);

    assign Count         = count;
    assign InstValid     = (count != '0);
    assign InstOut       = inst_mem[head];
    assign InstAddrOut   = addr_mem[head];

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            pc          <= RESET_PC;
            rsp_pc      <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
            count       <= '0;
            head        <= '0;
            tail        <= '0;
        end else if (JumpFlag) begin
            // Everything still in flight after this cycle belongs to the old stream.
            pc          <= JumpAddr;
            rsp_pc      <= JumpAddr;
            outstanding <= out_after_rsp;
            drop_cnt    <= out_after_rsp;
            count       <= '0;
            head        <= '0;
            tail        <= '0;
        end else begin
            if (req_fire) begin
                pc <= pc + ADDR_W'(PC_STEP);
            end
            outstanding <= out_after_rsp + OW'(req_fire);
            if (FetchRspValid && (drop_cnt != '0)) begin
                drop_cnt <= drop_cnt - OW'(1);
            end
            if (push) begin
                tail   <= tail + PW'(1);
                rsp_pc <= rsp_pc + ADDR_W'(PC_STEP);
            end
            if (pop) begin
                head <= head + PW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge Clk) begin
        if (push) begin
            inst_mem[tail] <= FetchRspInst;
            addr_mem[tail] <= rsp_pc;
        end
    end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Directed bench for inst_fetch_queue: 64-bit instance with a queue-based memory model, plus a 32-bit wrap instance.
module tb_inst_fetch_queue;

    logic        Clk;
    logic        Rst;
    logic        JumpFlag;
    logic [63:0] JumpAddr;
    logic        FetchReqValid;
    logic [63:0] FetchReqAddr;
    logic        FetchReqReady;
    logic        FetchRspValid;
    logic [31:0] FetchRspInst;
    logic        InstValid;
    logic [31:0] InstOut;
    logic [63:0] InstAddrOut;
    logic        InstReady;
    logic [2:0]  Count;

    logic        b_req_vld;
    logic [31:0] b_req_addr;
    logic        b_rsp_vld;
    logic [31:0] b_rsp_inst;
    logic        b_inst_vld;
    logic [31:0] b_inst;
    logic [31:0] b_inst_addr;
    logic [2:0]  b_count;

    logic        rsp_en;
    logic [63:0] pend[$];
    logic [31:0] pend2[$];
    logic [31:0] b_pops[$];

    int n_checks = 0;
    int n_fail   = 0;
    int max_cnt;

    inst_fetch_queue dut (
        .Clk(Clk), .Rst(Rst), .JumpFlag(JumpFlag), .JumpAddr(JumpAddr),
        .FetchReqValid(FetchReqValid), .FetchReqAddr(FetchReqAddr), .FetchReqReady(FetchReqReady),
        .FetchRspValid(FetchRspValid), .FetchRspInst(FetchRspInst),
        .InstValid(InstValid), .InstOut(InstOut), .InstAddrOut(InstAddrOut),
        .InstReady(InstReady), .Count(Count)
    );

    inst_fetch_queue #(.ADDR_W(32), .RESET_PC(32'hFFFF_FFF8)) dut32 (
        .Clk(Clk), .Rst(Rst), .JumpFlag(1'b0), .JumpAddr(32'h0),
        .FetchReqValid(b_req_vld), .FetchReqAddr(b_req_addr), .FetchReqReady(1'b1),
        .FetchRspValid(b_rsp_vld), .FetchRspInst(b_rsp_inst),
        .InstValid(b_inst_vld), .InstOut(b_inst), .InstAddrOut(b_inst_addr),
        .InstReady(1'b1), .Count(b_count)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    function automatic logic [31:0] inst_of(input logic [63:0] a);
        return a[31:0] ^ 32'h1357_9BDF;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: account for handshakes seen before the edge, then drive the memory side for the next cycle.
    task automatic cycle();
        #1;
        if (FetchRspValid) void'(pend.pop_front());
        if (FetchReqValid && FetchReqReady) pend.push_back(FetchReqAddr);
        if (b_rsp_vld) void'(pend2.pop_front());
        if (b_req_vld) pend2.push_back(b_req_addr);
        if (b_inst_vld) b_pops.push_back(b_inst_addr);
        @(posedge Clk);
        #1;
        FetchRspValid = rsp_en && (pend.size() > 0);
        FetchRspInst  = (pend.size() > 0) ? inst_of(pend[0]) : 32'h0;
        b_rsp_vld     = (pend2.size() > 0);
        b_rsp_inst    = (pend2.size() > 0) ? inst_of({32'h0, pend2[0]}) : 32'h0;
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!InstValid && n < 20) begin
            cycle();
            n++;
        end
        check(tag, {63'h0, InstValid}, 64'h1);
    endtask

    initial begin
        Rst = 1'b1; JumpFlag = 1'b0; JumpAddr = '0; FetchReqReady = 1'b1;
        FetchRspValid = 1'b0; FetchRspInst = '0; InstReady = 1'b1; rsp_en = 1'b1;
        b_rsp_vld = 1'b0; b_rsp_inst = '0;
        repeat (3) cycle();
        check("rst_req_vld", {63'h0, FetchReqValid}, 64'h0);
        check("rst_inst_vld", {63'h0, InstValid}, 64'h0);
        check("rst_count", {61'h0, Count}, 64'h0);
        check("rst_pc", FetchReqAddr, 64'h8000_0000);

        // T1: streaming with latency-1 memory
        Rst = 1'b0; #1;
        check("t1_req_vld", {63'h0, FetchReqValid}, 64'h1);
        cycle();
        check("t1_pc_step", FetchReqAddr, 64'h8000_0004);
        check("t1_not_yet", {63'h0, InstValid}, 64'h0);
        cycle();
        check("t1_first_vld", {63'h0, InstValid}, 64'h1);
        check("t1_first_addr", InstAddrOut, 64'h8000_0000);
        check("t1_first_inst", {32'h0, InstOut}, {32'h0, inst_of(64'h8000_0000)});
        cycle();
        check("t1_addr1", InstAddrOut, 64'h8000_0004);
        check("t1_count1", {61'h0, Count}, 64'h1);
        cycle();
        check("t1_addr2", InstAddrOut, 64'h8000_0008);

        // T2: decode stalls, queue fills to DEPTH and issue stops
        InstReady = 1'b0;
        repeat (6) cycle();
        check("t2_req_stop", {63'h0, FetchReqValid}, 64'h0);
        check("t2_count_full", {61'h0, Count}, 64'h4);
        check("t2_pc_hold", FetchReqAddr, 64'h8000_0018);
        check("t2_head", InstAddrOut, 64'h8000_0008);
        InstReady = 1'b1;
        cycle();
        InstReady = 1'b0; #1;
        check("t2_pop_reissue", {63'h0, FetchReqValid}, 64'h1);
        check("t2_pop_addr", FetchReqAddr, 64'h8000_0018);
        check("t2_pop_head", InstAddrOut, 64'h8000_000C);
        cycle();
        check("t2_one_req", {63'h0, FetchReqValid}, 64'h0);
        check("t2_one_pc", FetchReqAddr, 64'h8000_001C);
        cycle();
        check("t2_refill", {61'h0, Count}, 64'h4);

        // T3: jump with two requests outstanding
        rsp_en = 1'b0; FetchReqReady = 1'b0; InstReady = 1'b1;
        repeat (4) cycle();
        check("t3_drained", {61'h0, Count}, 64'h0);
        FetchReqReady = 1'b1;
        repeat (2) cycle();
        check("t3_pc_pre", FetchReqAddr, 64'h8000_0024);
        JumpFlag = 1'b1; JumpAddr = 64'h8000_0100; rsp_en = 1'b1; InstReady = 1'b0; #1;
        check("t3_jump_noreq", {63'h0, FetchReqValid}, 64'h0);
        cycle();
        JumpFlag = 1'b0; #1;
        check("t3_flush", {61'h0, Count}, 64'h0);
        check("t3_pc_jump", FetchReqAddr, 64'h8000_0100);
        check("t3_drop", {60'h0, dut.drop_cnt}, 64'h2);
        wait_valid("t3_wait_vld");
        check("t3_addr", InstAddrOut, 64'h8000_0100);
        check("t3_inst", {32'h0, InstOut}, {32'h0, inst_of(64'h8000_0100)});
        max_cnt = 0;
        repeat (8) begin
            cycle();
            if (int'(Count) > max_cnt) max_cnt = int'(Count);
        end
        check("t3_max_count", 64'(max_cnt), 64'h4);
        check("t3_head_hold", InstAddrOut, 64'h8000_0100);

        // T4: jump coincident with a response and a pop, Count=2
        rsp_en = 1'b0; InstReady = 1'b1;
        repeat (2) cycle();
        InstReady = 1'b0; rsp_en = 1'b1;
        cycle();
        JumpFlag = 1'b1; JumpAddr = 64'h8000_0200; InstReady = 1'b1; FetchReqReady = 1'b0; #1;
        check("t4_pre_count", {61'h0, Count}, 64'h2);
        check("t4_pre_rsp", {63'h0, FetchRspValid}, 64'h1);
        cycle();
        JumpFlag = 1'b0; #1;
        check("t4_count0", {61'h0, Count}, 64'h0);
        check("t4_inst_vld0", {63'h0, InstValid}, 64'h0);
        check("t4_drop", {60'h0, dut.drop_cnt}, 64'h1);
        check("t4_outstanding", {60'h0, dut.outstanding}, 64'h1);

        // T5: memory not ready, request held steady
        for (int i = 0; i < 5; i++) begin
            cycle();
            check("t5_req_vld", {63'h0, FetchReqValid}, 64'h1);
            check("t5_req_addr", FetchReqAddr, 64'h8000_0200);
        end
        FetchReqReady = 1'b1;
        wait_valid("t5_wait_vld");
        check("t5_addr", InstAddrOut, 64'h8000_0200);

        // T6: 32-bit instance wraps through zero in order
        check("t6_npops", {63'h0, b_pops.size() >= 3}, 64'h1);
        if (b_pops.size() >= 3) begin
            check("t6_pop0", {32'h0, b_pops[0]}, 64'hFFFF_FFF8);
            check("t6_pop1", {32'h0, b_pops[1]}, 64'hFFFF_FFFC);
            check("t6_pop2", {32'h0, b_pops[2]}, 64'h0000_0000);
        end

        // Reset mid-operation
        Rst = 1'b1; pend.delete(); pend2.delete();
        FetchRspValid = 1'b0; b_rsp_vld = 1'b0; #1;
        check("mrst_count", {61'h0, Count}, 64'h0);
        check("mrst_inst_vld", {63'h0, InstValid}, 64'h0);
        check("mrst_req_vld", {63'h0, FetchReqValid}, 64'h0);
        check("mrst_pc", FetchReqAddr, 64'h8000_0000);
        cycle();
        Rst = 1'b0; #1;
        check("mrst_release", {63'h0, FetchReqValid}, 64'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
